// File: rtl/io_pkg.sv
// Shared definitions for the multi-channel programmed-I/O unit:
// default geometry, flag reset values and the interrupt priority encoder.
package io_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NCH_DEF    = 4;

    // Input flags start empty, output flags start idle (ready for a word).
    localparam logic FGI_RST = 1'b0;
    localparam logic FGO_RST = 1'b1;

    // Lowest set bit index of a 16-bit request vector (bit 0 has highest priority).
    // Returns 0 when no bit is set; callers only use it when a request exists.
    function automatic int lowest_set(input logic [15:0] v);
        int idx;
        idx = 0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_channel.sv
// One I/O channel: input register INPR with flag FGI, output register OUTR
// with flag FGO, and the device-side valid/ready handshakes.
module io_channel
    import io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              cpu_inp,
    input  logic              cpu_out,
    input  logic [DATA_W-1:0] cpu_out_data,
    output logic [DATA_W-1:0] inpr,
    output logic              fgi,
    output logic              fgo
);

    logic [DATA_W-1:0] inpr_q, inpr_d;
    logic [DATA_W-1:0] outr_q, outr_d;
    logic              fgi_q, fgi_d;
    logic              fgo_q, fgo_d;

    // Next-state for both directions; capture needs FGI=0, so it never races an INP clear.
    always_comb begin
        inpr_d = inpr_q;
        outr_d = outr_q;
        fgi_d  = fgi_q;
        fgo_d  = fgo_q;
        if (in_valid && !fgi_q) begin
            inpr_d = in_data;
            fgi_d  = 1'b1;
        end else if (cpu_inp) begin
            fgi_d = 1'b0;
        end
        if (cpu_out && fgo_q) begin
            outr_d = cpu_out_data;
            fgo_d  = 1'b0;
        end else if (!fgo_q && out_ready) begin
            fgo_d = 1'b1;
        end
    end

    // Channel state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inpr_q <= '0;
            outr_q <= '0;
            fgi_q  <= FGI_RST;
            fgo_q  <= FGO_RST;
        end else begin
            inpr_q <= inpr_d;
            outr_q <= outr_d;
            fgi_q  <= fgi_d;
            fgo_q  <= fgo_d;
        end
    end

    assign in_ready  = ~fgi_q;
    assign out_valid = ~fgo_q;
    assign out_data  = outr_q;
    assign inpr      = inpr_q;
    assign fgi       = fgi_q;
    assign fgo       = fgo_q;

endmodule

// File: rtl/io_channel_unit.sv
// Multi-channel programmed-I/O unit: NCH io_channel instances plus the
// interrupt-enable flip-flop IEN, request flip-flop R with its latched vector,
// and the channel-select muxes for INP/OUT/SKI/SKO.
// Optional feature macro: IO_IRQ_MASK_EN adds a software-loadable per-channel
// interrupt mask (loaded by cpu_msk from cpu_out_data[NCH-1:0], needs NCH <= DATA_W).
module io_channel_unit
    import io_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NCH    = NCH_DEF,
    parameter int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH*DATA_W-1:0] in_data,
    output logic [NCH-1:0]        in_ready,
    output logic [NCH-1:0]        out_valid,
    output logic [NCH*DATA_W-1:0] out_data,
    input  logic [NCH-1:0]        out_ready,
    input  logic [CH_W-1:0]       cpu_ch_sel,
    input  logic                  cpu_inp,
    input  logic                  cpu_out,
    input  logic                  cpu_ion,
    input  logic                  cpu_iof,
    input  logic                  cpu_msk,
    input  logic [DATA_W-1:0]     cpu_out_data,
    output logic [DATA_W-1:0]     cpu_in_data,
    output logic                  fgi_sel,
    output logic                  fgo_sel,
    input  logic                  irq_window,
    input  logic                  irq_take,
    output logic                  irq,
    output logic [CH_W-1:0]       irq_vector,
    output logic                  ien
);

    logic [DATA_W-1:0] inpr [NCH];
    logic [NCH-1:0]    fgi;
    logic [NCH-1:0]    fgo;
    logic [NCH-1:0]    ch_inp;
    logic [NCH-1:0]    ch_out;
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    pend;

    logic              ien_q, ien_d;
    logic              irq_q, irq_d;
    logic [CH_W-1:0]   vec_q, vec_d;

    // Channel decode; a select value with no matching channel reads 0 and strobes nothing.
    always_comb begin
        ch_inp      = '0;
        ch_out      = '0;
        cpu_in_data = '0;
        fgi_sel     = 1'b0;
        fgo_sel     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cpu_ch_sel == CH_W'(i)) begin
                ch_inp[i]   = cpu_inp;
                ch_out[i]   = cpu_out;
                cpu_in_data = inpr[i];
                fgi_sel     = fgi[i];
                fgo_sel     = fgo[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        io_channel #(.DATA_W(DATA_W)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid[g]),
            .in_data      (in_data[g*DATA_W +: DATA_W]),
            .in_ready     (in_ready[g]),
            .out_valid    (out_valid[g]),
            .out_data     (out_data[g*DATA_W +: DATA_W]),
            .out_ready    (out_ready[g]),
            .cpu_inp      (ch_inp[g]),
            .cpu_out      (ch_out[g]),
            .cpu_out_data (cpu_out_data),
            .inpr         (inpr[g]),
            .fgi          (fgi[g]),
            .fgo          (fgo[g])
        );
    end

`ifdef IO_IRQ_MASK_EN
    logic [NCH-1:0] mask_q, mask_d;

    // Mask reload from the low AC bits on cpu_msk.
    always_comb begin
        mask_d = mask_q;
        if (cpu_msk) mask_d = cpu_out_data[NCH-1:0];
    end

    // Mask register, every channel enabled out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask_q <= '1;
        else        mask_q <= mask_d;
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    assign pend = (fgi | fgo) & mask;

    // IEN and R next-state; IOF and the interrupt cycle override ION, irq_take overrides a set.
    always_comb begin
        ien_d = ien_q;
        irq_d = irq_q;
        vec_d = vec_q;
        if (cpu_ion) ien_d = 1'b1;
        if (cpu_iof || irq_take) ien_d = 1'b0;
        if (irq_take) begin
            irq_d = 1'b0;
        end else if (irq_window && ien_q && (|pend) && !irq_q) begin
            irq_d = 1'b1;
            vec_d = CH_W'(lowest_set(16'(pend)));
        end
    end

    // Interrupt control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ien_q <= 1'b0;
            irq_q <= 1'b0;
            vec_q <= '0;
        end else begin
            ien_q <= ien_d;
            irq_q <= irq_d;
            vec_q <= vec_d;
        end
    end

    assign ien        = ien_q;
    assign irq        = irq_q;
    assign irq_vector = vec_q;

endmodule
